// File: rtl/ledsuit_pkg.sv
// ledsuit_pkg: shared FSM encoding and 50 MHz WS2812 timing defaults
package ledsuit_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, LATCH} ws_state_t;

    localparam int WS_T_BIT   = 62;
    localparam int WS_T0H     = 20;
    localparam int WS_T1H     = 40;
    localparam int WS_T_LATCH = 2500;

endpackage

// File: rtl/ws2812_bit_timer.sv
// ws2812_bit_timer: per-bit phase counter giving high/low level and bit boundaries
module ws2812_bit_timer #(
    parameter int T_BIT = 62,
    parameter int T0H   = 20,
    parameter int T1H   = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic bit_val,
    output logic high,
    output logic end_bit,
    output logic bit_start
);
    localparam int PW = $clog2(T_BIT);
    localparam logic [PW-1:0] LAST = PW'(T_BIT - 1);
    localparam logic [PW-1:0] H0   = PW'(T0H);
    localparam logic [PW-1:0] H1   = PW'(T1H);

    logic [PW-1:0] ph;

    always_ff @(posedge clk)
        ph <= (rst || !en || ph == LAST) ? '0 : ph + 1'b1;

    assign end_bit   = en && ph == LAST;
    assign bit_start = en && ph == '0;
    assign high      = ph < (bit_val ? H1 : H0);

endmodule

// File: rtl/ws2812_serializer.sv
// ws2812_serializer: streams a frame of GRB pixel words from memory onto a WS2812 strip.
// The bit timer runs one cycle ahead of strip_out so the line level can be registered.
module ws2812_serializer import ledsuit_pkg::*; #(
    parameter int NUM_PIXELS = 150,
    parameter int T_BIT      = WS_T_BIT,
    parameter int T0H        = WS_T0H,
    parameter int T1H        = WS_T1H,
    parameter int T_LATCH    = WS_T_LATCH
) (
    input  logic        clk_50,
    input  logic        rst,
    input  logic        start,
    output logic [12:0] mem_addr,
    output logic        mem_rd,
    input  logic [23:0] mem_rdata,
    output logic        strip_out,
    output logic        busy,
    output logic        frame_done
);
    localparam int LW = $clog2(T_LATCH + 1);
    localparam logic [12:0]   LAST_PIX  = 13'(NUM_PIXELS - 1);
    localparam logic [LW-1:0] LATCH_END = LW'(T_LATCH);

    ws_state_t state, state_n;
    logic [23:0] shreg, pf;
    logic [4:0] bit_idx;
    logic [12:0] pix;
    logic [LW-1:0] lcnt;
    logic pend, high, end_bit, bit_start, running;
    logic accept, prefetch, bit_end, pix_end, last_pix;

    assign running  = state == WAIT || state == SHIFT;
    assign accept   = state == IDLE && start;
    assign last_pix = pix == LAST_PIX;
    assign bit_end  = state == SHIFT && end_bit;
    assign pix_end  = bit_end && bit_idx == 5'd0;
    assign prefetch = state == SHIFT && bit_start && bit_idx == 5'd0 && !last_pix;

    ws2812_bit_timer #(.T_BIT(T_BIT), .T0H(T0H), .T1H(T1H)) u_timer (
        .clk       (clk_50),
        .rst       (rst),
        .en        (running),
        .bit_val   (shreg[23]),
        .high      (high),
        .end_bit   (end_bit),
        .bit_start (bit_start)
    );

    always_ff @(posedge clk_50)
        state <= rst ? IDLE : state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? FETCH : IDLE;
            FETCH:   state_n = WAIT;
            WAIT:    state_n = SHIFT;
            SHIFT:   state_n = (pix_end && last_pix) ? LATCH : SHIFT;
            LATCH:   state_n = lcnt == LATCH_END ? IDLE : LATCH;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            {mem_addr, mem_rd, strip_out, busy, frame_done, pend} <= '0;
            {shreg, pf, bit_idx, pix, lcnt} <= '0;
        end else begin
            mem_rd     <= accept || prefetch;
            mem_addr   <= accept ? 13'd0 : prefetch ? pix + 13'd1 : mem_addr;
            pend       <= mem_rd;
            pf         <= pend ? mem_rdata : pf;
            strip_out  <= running && high;
            busy       <= state_n != IDLE;
            frame_done <= state == LATCH && lcnt == LATCH_END;
            lcnt       <= state == LATCH ? lcnt + 1'b1 : '0;
            if (accept)
                pix <= '0;
            else if (pix_end && !last_pix)
                pix <= pix + 13'd1;
            // the last pixel holds its final bit; LATCH takes over from here
            if (state == WAIT || (pix_end && !last_pix)) begin
                shreg   <= state == WAIT ? mem_rdata : pf;
                bit_idx <= 5'd23;
            end else if (bit_end && bit_idx != 5'd0) begin
                shreg   <= shreg << 1;
                bit_idx <= bit_idx - 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_ws2812_serializer.sv
// tb_ws2812_serializer: randomized and directed frame checks against a waveform model
// built directly from pixel data and bit timing.
module tb_ws2812_serializer;
    localparam int NP = 2, TB = 10, T0 = 3, T1 = 7, TL = 20;
    localparam int FRAME = NP * 24 * TB;

    logic clk_50 = 0;
    always #5 clk_50 = ~clk_50;

    logic rst = 1, start = 0, rst1 = 1, start1 = 0;
    logic [12:0] mem_addr, mem_addr1;
    logic mem_rd, mem_rd1;
    logic [23:0] mem_rdata = '0, mem_rdata1 = '0;
    logic strip_out, busy, frame_done, strip1, busy1, done1;
    logic [23:0] mem [NP];
    logic [23:0] mem1;
    int tests = 0, fails = 0;

    bit q_strip[$], q_rd[$], q_busy[$], q_done[$];
    logic [12:0] q_addr[$];

    ws2812_serializer #(.NUM_PIXELS(NP), .T_BIT(TB), .T0H(T0), .T1H(T1), .T_LATCH(TL)) dut (
        .clk_50(clk_50), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .strip_out(strip_out), .busy(busy), .frame_done(frame_done));

    ws2812_serializer #(.NUM_PIXELS(1), .T_BIT(TB), .T0H(T0), .T1H(T1), .T_LATCH(TL)) dut1 (
        .clk_50(clk_50), .rst(rst1), .start(start1), .mem_addr(mem_addr1), .mem_rd(mem_rd1),
        .mem_rdata(mem_rdata1), .strip_out(strip1), .busy(busy1), .frame_done(done1));

    always @(posedge clk_50) begin
        if (mem_rd) mem_rdata <= mem[mem_addr[0]];
        if (mem_rd1) mem_rdata1 <= mem1;
    end

    task automatic clear;
        q_strip.delete(); q_rd.delete(); q_busy.delete(); q_done.delete(); q_addr.delete();
    endtask

    task automatic record(input int n);
        repeat (n) begin
            @(negedge clk_50);
            q_strip.push_back(strip_out); q_rd.push_back(mem_rd); q_busy.push_back(busy);
            q_done.push_back(frame_done); q_addr.push_back(mem_addr);
        end
    endtask

    // f is the sample index of the first cycle after start was accepted
    task automatic check_frame(input string nm, input int f);
        bit exp[$];
        int e, bad, first, nd;
        logic [12:0] rds[$];
        e = f + 2 + FRAME;
        for (int p = 0; p < NP; p++)
            for (int b = 23; b >= 0; b--)
                for (int k = 0; k < TB; k++) exp.push_back(k < (mem[p][b] ? T1 : T0));
        tests++;
        if (q_strip.size() <= e + TL) begin
            fails++;
            $display("FAIL %s capture: got %0d samples, expected more than %0d", nm, q_strip.size(), e + TL);
            return;
        end
        tests++;
        if (q_busy[f] !== 1 || q_rd[f] !== 1 || q_addr[f] !== 0) begin
            fails++;
            $display("FAIL %s first_cycle: busy=%b rd=%b addr=%0d, expected 1 1 0", nm, q_busy[f], q_rd[f], q_addr[f]);
        end
        tests++;
        if (q_strip[f] !== 0 || q_strip[f+1] !== 0 || q_strip[f+2] !== 1) begin
            fails++;
            $display("FAIL %s latency: strip=%b%b%b, expected 001", nm, q_strip[f], q_strip[f+1], q_strip[f+2]);
        end
        bad = 0; first = 0;
        for (int i = 0; i < FRAME; i++)
            if (q_strip[f+2+i] !== exp[i]) begin
                if (bad == 0) first = i;
                bad++;
            end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s waveform: %0d bad samples, first at bit %0d phase %0d got %b expected %b",
                     nm, bad, first / TB, first % TB, q_strip[f+2+first], exp[first]);
        end
        bad = 0;
        for (int i = 0; i < TL; i++)
            if (q_strip[e+i] !== 0 || q_done[e+i] !== 0 || q_busy[e+i] !== 1) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s latch_gap: %0d bad cycles, expected 0", nm, bad);
        end
        tests++;
        if (q_done[e+TL] !== 1 || q_busy[e+TL] !== 0) begin
            fails++;
            $display("FAIL %s frame_end: done=%b busy=%b, expected 1 0", nm, q_done[e+TL], q_busy[e+TL]);
        end
        nd = 0;
        for (int i = f; i <= e + TL; i++) begin
            if (q_done[i]) nd++;
            if (q_rd[i]) rds.push_back(q_addr[i]);
        end
        tests++;
        if (nd != 1) begin
            fails++;
            $display("FAIL %s done_count: got %0d, expected 1", nm, nd);
        end
        bad = (rds.size() != NP) ? 1 : 0;
        foreach (rds[i]) if (rds[i] !== 13'(i)) bad = 1;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s reads: got %0d reads (first addr %0d), expected %0d reads 0..%0d",
                     nm, rds.size(), rds.size() ? rds[0] : 0, NP, NP - 1);
        end
    endtask

    task automatic test_reset;
        rst = 1; rst1 = 1; start = 1; start1 = 1;
        repeat (3) @(negedge clk_50);
        tests++;
        if ({strip_out, mem_rd, mem_addr, busy, frame_done} !== '0) begin
            fails++;
            $display("FAIL reset_main: got strip=%b rd=%b addr=%0d busy=%b done=%b, expected all 0",
                     strip_out, mem_rd, mem_addr, busy, frame_done);
        end
        tests++;
        if ({strip1, mem_rd1, mem_addr1, busy1, done1} !== '0) begin
            fails++;
            $display("FAIL reset_single: got strip=%b rd=%b addr=%0d busy=%b done=%b, expected all 0",
                     strip1, mem_rd1, mem_addr1, busy1, done1);
        end
        start = 0; start1 = 0; rst = 0; rst1 = 0;
        @(negedge clk_50);
    endtask

    task automatic test_directed;
        int h;
        mem[0] = 24'hFF00A5; mem[1] = 24'h000001;
        clear; start = 1; record(1); start = 0; record(FRAME + TL + 8);
        check_frame("directed", 0);
        h = 0;
        for (int k = 0; k < TB; k++) h += (q_strip[2 + 23*TB + k] == (k < T1)) ? 1 : 0;
        tests++;
        if (h != TB) begin
            fails++;
            $display("FAIL p0_bit0: %0d of %0d phases matched 7 high / 3 low", h, TB);
        end
        h = 0;
        for (int k = 0; k < TB; k++) h += q_strip[2 + 47*TB + k];
        tests++;
        if (h != T1) begin
            fails++;
            $display("FAIL p1_last_bit: got %0d high cycles, expected %0d", h, T1);
        end
    endtask

    task automatic test_start_ignored;
        int bad;
        mem[0] = 24'($urandom); mem[1] = 24'($urandom);
        clear; start = 1; record(1); start = 0; record(100);
        start = 1; record(1); start = 0; record(FRAME + TL + 30);
        check_frame("start_in_shift", 0);
        bad = 0;
        for (int i = 3 + FRAME + TL; i < q_busy.size(); i++) if (q_busy[i] || q_strip[i]) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL no_queued_frame: %0d busy/high cycles after frame, expected 0", bad);
        end
    endtask

    task automatic test_reset_mid;
        int r, bad;
        mem[0] = 24'($urandom); mem[1] = 24'($urandom);
        clear; start = 1; record(1); start = 0; record(2 + 24*TB + 50);
        r = q_strip.size();
        rst = 1; record(1); rst = 0;
        tests++;
        if (q_strip[r] !== 0 || q_busy[r] !== 0 || q_done[r] !== 0) begin
            fails++;
            $display("FAIL rst_mid: strip=%b busy=%b done=%b, expected 0 0 0", q_strip[r], q_busy[r], q_done[r]);
        end
        record(FRAME + TL + 5);
        bad = 0;
        for (int i = r; i < q_strip.size(); i++) if (q_strip[i] || q_busy[i] || q_rd[i]) bad++;
        for (int i = 0; i < q_done.size(); i++) if (q_done[i]) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL rst_abort: %0d active cycles after reset, expected 0", bad);
        end
        clear; start = 1; record(1); start = 0; record(FRAME + TL + 8);
        check_frame("after_rst", 0);
    endtask

    task automatic test_back_to_back;
        mem[0] = 24'($urandom); mem[1] = 24'($urandom);
        clear; start = 1;
        record(2 * (FRAME + TL + 3) + 4);
        start = 0;
        check_frame("b2b_first", 0);
        check_frame("b2b_second", FRAME + TL + 3);
        record(FRAME + TL + 10);
    endtask

    task automatic test_random;
        for (int n = 0; n < 3; n++) begin
            mem[0] = 24'($urandom); mem[1] = 24'($urandom);
            clear; start = 1; record(1); start = 0; record(FRAME + TL + 8);
            check_frame("random", 0);
            record($urandom_range(0, 5));
        end
    endtask

    task automatic test_single_pixel;
        int run, pulses, bad_h, bad_l, rise, reads, dones, badaddr;
        bit prev;
        mem1 = 24'h000000;
        run = 0; pulses = 0; bad_h = 0; bad_l = 0; rise = -1; reads = 0; dones = 0; badaddr = 0; prev = 0;
        start1 = 1; @(negedge clk_50); start1 = 0;
        for (int i = 0; i < 24*TB + TL + 10; i++) begin
            if (i > 0) @(negedge clk_50);
            if (mem_rd1) begin reads++; if (mem_addr1 !== 0) badaddr++; end
            if (done1) dones++;
            if (strip1 !== prev) begin
                if (prev) begin pulses++; if (run != T0) bad_h++; end
                else if (rise < 0) rise = i;
                else if (run != TB - T0) bad_l++;
                run = 0;
            end
            run++;
            prev = strip1;
        end
        tests++;
        if (pulses != 24 || bad_h != 0 || bad_l != 0) begin
            fails++;
            $display("FAIL single_pulses: got %0d pulses, %0d bad highs, %0d bad lows, expected 24 0 0", pulses, bad_h, bad_l);
        end
        tests++;
        if (rise != 2) begin
            fails++;
            $display("FAIL single_latency: first rise at %0d, expected 2", rise);
        end
        tests++;
        if (reads != 1 || badaddr != 0) begin
            fails++;
            $display("FAIL single_reads: got %0d reads (%0d bad addr), expected 1", reads, badaddr);
        end
        tests++;
        if (dones != 1 || busy1 !== 0) begin
            fails++;
            $display("FAIL single_done: got %0d done pulses busy=%b, expected 1 0", dones, busy1);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_start_ignored;
        test_reset_mid;
        test_back_to_back;
        test_random;
        test_single_pixel;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
